// File: rtl/mips_muldiv_if.sv
// Bus between the core and the iterative multiply/divide unit.
//
// Handshake: the core raises start with op/S/T for one cycle while busy=0;
// the unit samples them on that rising edge and ignores start whenever busy=1.
// A mul/div raises busy from that edge until its result is written.
// The unit then pulses done for exactly one cycle with hi/lo already updated.
// abort cancels an operation in flight and never produces done.
// Move ops (MTHI/MTLO) complete at the sampling edge with no busy and no done.
interface mips_muldiv_if #(parameter int W = 32);
  logic         start;
  logic [2:0]   op;
  logic         abort;
  logic [W-1:0] S;
  logic [W-1:0] T;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  modport master (output start, op, abort, S, T,
                  input  busy, done, hi, lo, dbg_state);
  modport slave  (input  start, op, abort, S, T,
                  output busy, done, hi, lo, dbg_state);
endinterface

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit with its own HI/LO register pair.
// Operands are reduced to magnitudes at launch, W unsigned steps run, and one
// fix-up cycle applies the signs before HI/LO are written.
module mips_muldiv #(parameter int W = 32) (
  input logic         clock,
  input logic         reset,
  mips_muldiv_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [W-1:0]   opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic           is_div, neg_s, neg_t, div0;
  logic [W-1:0]   hi_r, lo_r;
  logic           done_r;

  logic [W-1:0]   s_mag, t_mag;
  logic [W:0]     mul_sum, div_trial;
  logic [2*W-1:0] mul_nx, div_nx, prod;
  logic [W-1:0]   quo, rem;

  // Magnitudes; the most-negative value maps to 2^(W-1) as an unsigned number.
  assign s_mag = (!bus.op[0] && bus.S[W-1]) ? -bus.S : bus.S;
  assign t_mag = (!bus.op[0] && bus.T[W-1]) ? -bus.T : bus.T;

  // One shift-add multiply step: add multiplicand to the upper half on LSB, shift right.
  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
  assign mul_nx  = {mul_sum, acc[W-1:1]};

  // One restoring divide step: trial-subtract from {rem, next dividend bit}.
  assign div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, opnd};
  assign div_nx    = div_trial[W] ? {acc[2*W-2:0], 1'b0}
                                  : {div_trial[W-1:0], acc[W-2:0], 1'b1};

  // Sign fix-up; divide by zero forces an all-ones quotient, remainder is S itself.
  assign prod = (neg_s ^ neg_t) ? -acc : acc;
  assign quo  = div0 ? {W{1'b1}} : ((neg_s ^ neg_t) ? -acc[W-1:0] : acc[W-1:0]);
  assign rem  = neg_s ? -acc[2*W-1:W] : acc[2*W-1:W];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: launch on a non-move start, W steps, one fix cycle; abort returns to IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start && !bus.op[2]) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end

  // Datapath, counter and HI/LO; abort freezes everything for that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_s  <= 1'b0;
      neg_t  <= 1'b0;
      div0   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!bus.abort) begin
        unique case (state)
          IDLE: if (bus.start) begin
            if (bus.op[2]) begin
              if (bus.op[0]) lo_r <= bus.S;
              else           hi_r <= bus.S;
            end else begin
              is_div <= bus.op[1];
              neg_s  <= !bus.op[0] && bus.S[W-1];
              neg_t  <= !bus.op[0] && bus.T[W-1];
              div0   <= bus.op[1] && (bus.T == '0);
              opnd   <= bus.op[1] ? t_mag : s_mag;
              acc    <= {{W{1'b0}}, (bus.op[1] ? s_mag : t_mag)};
              cnt    <= CW'(W - 1);
            end
          end
          RUN: begin
            acc <= is_div ? div_nx : mul_nx;
            cnt <= cnt - 1'b1;
          end
          FIX: begin
            done_r <= 1'b1;
            if (is_div) begin
              hi_r <= rem;
              lo_r <= quo;
            end else begin
              hi_r <= prod[2*W-1:W];
              lo_r <= prod[W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.dbg_state = state;
endmodule
